// File: rtl/assoc_cache.sv
// assoc_cache: set-associative (1 or 2 ways), write-through, write-allocate cache
// with an integrated burst-fill controller.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   cpu_addr/din     CPU request address and write data (held while cpu_stall=1)
//   cpu_rd/cpu_wr    CPU read / write request (write wins when both are set)
//   cpu_dout         hit word, combinational
//   cpu_stall        request not complete this cycle
//   mem_addr/din     backing-memory address (word aligned) and write-through data
//   mem_rd/mem_wr    one-cycle memory read / write strobes
//   mem_dout/valid   in-order read return data and its strobe
//
// A hit completes in the same cycle. A miss picks a victim, invalidates it,
// streams W pipelined reads to memory and writes returns into the victim; on
// the last return the tag and valid bit go in and the held request replays as
// a hit.

// One way of the cache: per-set valid bit and tag plus W data words per set.
module assoc_cache_way #(
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 16,
    parameter int SET_BITS  = 6,
    parameter int WORD_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // lookup
    input  logic [SET_BITS-1:0]  rd_set,
    input  logic [WORD_BITS-1:0] rd_word,
    input  logic [TAG_W-1:0]     cmp_tag,
    output logic                 vld,
    output logic                 hit,
    output logic [DATA_W-1:0]    rdata,
    // data word write
    input  logic                 we,
    input  logic [SET_BITS-1:0]  wr_set,
    input  logic [WORD_BITS-1:0] wr_word,
    input  logic [DATA_W-1:0]    wdata,
    // valid/tag write
    input  logic                 meta_we,
    input  logic [SET_BITS-1:0]  meta_set,
    input  logic [TAG_W-1:0]     meta_tag,
    input  logic                 meta_vld
);
    localparam int SETS = 1 << SET_BITS;
    localparam int W    = 1 << WORD_BITS;

    logic [SETS-1:0]   vld_q;
    logic [TAG_W-1:0]  tags [SETS];
    logic [DATA_W-1:0] data [SETS*W];

    assign vld   = vld_q[rd_set];
    assign hit   = vld && (tags[rd_set] == cmp_tag);
    assign rdata = data[{rd_set, rd_word}];

    always_ff @(posedge clk) begin
        if (!rst_n)
            vld_q <= '0;
        else if (meta_we)
            vld_q[meta_set] <= meta_vld;
    end

    // Tag and data arrays are not cleared, but nothing lands in them while
    // reset is held, so an aborted fill leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && meta_we && meta_vld)
            tags[meta_set] <= meta_tag;
        if (rst_n && we)
            data[{wr_set, wr_word}] <= wdata;
    end
endmodule

module assoc_cache #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int SET_BITS  = 6,
    parameter int WORD_BITS = 3,
    parameter int WAYS      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_valid
);
    localparam int TAG_W = ADDR_W - SET_BITS - WORD_BITS - 1;
    localparam int SETS  = 1 << SET_BITS;
    localparam int W     = 1 << WORD_BITS;
    localparam int CNT_W = WORD_BITS + 1;
    localparam logic [CNT_W-1:0] W_CNT  = CNT_W'(W);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_nx;

    // address split
    logic [TAG_W-1:0]     a_tag;
    logic [SET_BITS-1:0]  a_set;
    logic [WORD_BITS-1:0] a_word;
    logic                 unused_byte_sel;

    assign a_tag           = cpu_addr[ADDR_W-1 -: TAG_W];
    assign a_set           = cpu_addr[WORD_BITS+SET_BITS : WORD_BITS+1];
    assign a_word          = cpu_addr[WORD_BITS:1];
    assign unused_byte_sel = cpu_addr[0];

    // fill bookkeeping
    logic [TAG_W-1:0]    lat_tag;
    logic [SET_BITS-1:0] lat_set;
    logic                victim_q;
    logic [CNT_W-1:0]    req_cnt, rcv_cnt;
    logic [SETS-1:0]     lru;

    // way array
    logic [WAYS-1:0]             way_hit, way_vld, way_we, way_meta_we;
    logic [WAYS-1:0][DATA_W-1:0] way_rdata;
    logic [SET_BITS-1:0]         wr_set;
    logic [WORD_BITS-1:0]        wr_word;
    logic [DATA_W-1:0]           wr_data;
    logic [SET_BITS-1:0]         meta_set;
    logic                        meta_vld;

    logic req, hit, miss, wr_hit, fill_acc, fill_last, req_act;
    logic hit_idx, victim;
    logic [DATA_W-1:0] hit_data;

    assign req       = cpu_rd | cpu_wr;
    assign hit       = (state == IDLE) && req && (|way_hit);
    assign miss      = (state == IDLE) && req && !(|way_hit);
    assign wr_hit    = hit && cpu_wr;
    assign fill_acc  = (state == FILL) && mem_valid && (rcv_cnt < W_CNT);
    assign fill_last = fill_acc && (rcv_cnt == W_LAST);
    assign req_act   = (state == FILL) && (req_cnt < W_CNT);

    // At most one way matches, so the last match found is the only one.
    always_comb begin
        hit_idx  = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_idx  = 1'(w);
                hit_data = way_rdata[w];
            end
        end
    end

    // Victim: first invalid way (way 0 first), else the way LRU names.
    generate
        if (WAYS == 1) begin : g_victim1
            assign victim = 1'b0;
        end else begin : g_victim2
            assign victim = !way_vld[0]      ? 1'b0 :
                            !way_vld[WAYS-1] ? 1'b1 : lru[a_set];
        end
    endgenerate

    // Shared write ports: CPU write hits in IDLE, memory returns in FILL.
    assign wr_set   = (state == FILL) ? lat_set : a_set;
    assign wr_word  = (state == FILL) ? rcv_cnt[WORD_BITS-1:0] : a_word;
    assign wr_data  = (state == FILL) ? mem_dout : cpu_din;
    assign meta_set = (state == FILL) ? lat_set : a_set;
    assign meta_vld = (state == FILL);

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            // The victim is invalidated as soon as the miss is seen, so its
            // stale tag can never match words that are half overwritten.
            assign way_we[g]      = (wr_hit && hit_idx == 1'(g)) ||
                                    (fill_acc && victim_q == 1'(g));
            assign way_meta_we[g] = (miss && victim == 1'(g)) ||
                                    (fill_last && victim_q == 1'(g));

            assoc_cache_way #(
                .TAG_W    (TAG_W),
                .DATA_W   (DATA_W),
                .SET_BITS (SET_BITS),
                .WORD_BITS(WORD_BITS)
            ) u_way (
                .clk     (clk),
                .rst_n   (rst_n),
                .rd_set  (a_set),
                .rd_word (a_word),
                .cmp_tag (a_tag),
                .vld     (way_vld[g]),
                .hit     (way_hit[g]),
                .rdata   (way_rdata[g]),
                .we      (way_we[g]),
                .wr_set  (wr_set),
                .wr_word (wr_word),
                .wdata   (wr_data),
                .meta_we (way_meta_we[g]),
                .meta_set(meta_set),
                .meta_tag(lat_tag),
                .meta_vld(meta_vld)
            );
        end
    endgenerate

    // next state and outputs
    always_comb begin
        state_nx  = state;
        cpu_dout  = hit_data;
        cpu_stall = (state == FILL) || miss;
        mem_rd    = 1'b0;
        mem_wr    = wr_hit;
        mem_din   = cpu_din;
        mem_addr  = {cpu_addr[ADDR_W-1:1], 1'b0};
        case (state)
            IDLE: begin
                if (miss)
                    state_nx = FILL;
            end
            FILL: begin
                if (req_act) begin
                    mem_rd   = 1'b1;
                    mem_addr = {lat_tag, lat_set, req_cnt[WORD_BITS-1:0], 1'b0};
                end
                if (fill_last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lru      <= '0;
            req_cnt  <= '0;
            rcv_cnt  <= '0;
            lat_tag  <= '0;
            lat_set  <= '0;
            victim_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (miss) begin
                lat_tag  <= a_tag;
                lat_set  <= a_set;
                victim_q <= victim;
                req_cnt  <= '0;
                rcv_cnt  <= '0;
            end
            if (req_act)
                req_cnt <= req_cnt + 1'b1;
            if (fill_acc)
                rcv_cnt <= rcv_cnt + 1'b1;
            // LRU names the way to evict next: the one not just used.
            if (hit)
                lru[a_set] <= ~hit_idx;
            else if (fill_last)
                lru[lat_set] <= ~victim_q;
        end
    end
endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: instance 0 is the 2-way default, instance 1 is
// direct-mapped. Each has its own latency-L backing memory. A reference model
// (per-set tag lists in recency order) predicts hit/miss; write-through makes
// expected read data equal to the backing memory content.
module tb_assoc_cache;
    localparam int L          = 4;
    localparam int W          = 8;
    localparam int MISS_STALL = W + L + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n, cpu_rd, cpu_wr, cpu_stall, mem_rd, mem_wr, mem_valid;
    logic [15:0] cpu_addr [2];
    logic [15:0] cpu_din  [2];
    logic [15:0] cpu_dout [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_din  [2];
    logic [15:0] mem_dout [2];

    assoc_cache #(.WAYS(2)) dut2 (
        .clk(clk), .rst_n(rst_n[0]), .cpu_addr(cpu_addr[0]), .cpu_din(cpu_din[0]),
        .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]), .cpu_dout(cpu_dout[0]),
        .cpu_stall(cpu_stall[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
        .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_dout(mem_dout[0]),
        .mem_valid(mem_valid[0]));

    assoc_cache #(.WAYS(1)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .cpu_addr(cpu_addr[1]), .cpu_din(cpu_din[1]),
        .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]), .cpu_dout(cpu_dout[1]),
        .cpu_stall(cpu_stall[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
        .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_dout(mem_dout[1]),
        .mem_valid(mem_valid[1]));

    // ---------------- backing memory ----------------
    logic [15:0] wr_data [2][32768];
    bit          wr_seen [2][32768];
    logic        pv [2][L];
    logic [15:0] pa [2][L];

    function automatic logic [15:0] init_val(int k);
        return 16'(k * 40503 + 7) ^ 16'h3C3C;
    endfunction

    function automatic logic [15:0] mem_rdw(int i, int k);
        return wr_seen[i][k] ? wr_data[i][k] : init_val(k);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_wr[i]) begin
                wr_data[i][mem_addr[i][15:1]] <= mem_din[i];
                wr_seen[i][mem_addr[i][15:1]] <= 1'b1;
            end
            pv[i][0] <= mem_rd[i];
            pa[i][0] <= mem_addr[i];
            for (int k = 1; k < L; k++) begin
                pv[i][k] <= pv[i][k-1];
                pa[i][k] <= pa[i][k-1];
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ret
        assign mem_valid[g] = pv[g][L-1];
        assign mem_dout[g]  = pv[g][L-1] ? mem_rdw(g, int'(pa[g][L-1][15:1])) : 16'h0;
    end

    // ---------------- reference model ----------------
    int tagq [2][64][2];   // index 0 = least recently used
    int nq   [2][64];
    int ways_of [2] = '{2, 1};

    task automatic model_reset(input int i);
        for (int s = 0; s < 64; s++) nq[i][s] = 0;
    endtask

    task automatic model_access(input int i, input int a, output bit hit);
        int tag = (a >> 10) & 63;
        int set = (a >> 4) & 63;
        int pos = -1;
        for (int k = 0; k < nq[i][set]; k++)
            if (tagq[i][set][k] == tag) pos = k;
        hit = (pos >= 0);
        if (!hit) begin
            if (nq[i][set] < ways_of[i]) begin
                nq[i][set]++;
                pos = nq[i][set] - 1;
            end else begin
                pos = 0;
            end
        end
        for (int k = pos; k < nq[i][set] - 1; k++)
            tagq[i][set][k] = tagq[i][set][k+1];
        tagq[i][set][nq[i][set]-1] = tag;
    endtask

    // ---------------- checking ----------------
    int n_chk = 0, n_fail = 0;
    bit started = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle invariants
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                if (rst_n[i]) begin
                    chk("rd_wr_exclusive", int'(mem_rd[i] & mem_wr[i]), 0);
                    if (!cpu_rd[i] && !cpu_wr[i]) begin
                        chk("idle_stall", int'(cpu_stall[i]), 0);
                        chk("idle_mem_rd", int'(mem_rd[i]), 0);
                        chk("idle_mem_wr", int'(mem_wr[i]), 0);
                    end
                end
            end
        end
    end

    // One CPU access; starts and ends just after a rising edge.
    task automatic do_access(input int i, input int a, input bit rd, input bit wr,
                             input logic [15:0] din, output int stalls,
                             output logic [15:0] dout);
        bit hit, done;
        int exp_st, base;
        model_access(i, a, hit);
        exp_st = hit ? 0 : MISS_STALL;
        base   = a & 16'hFFF0;
        cpu_addr[i] = 16'(a);
        cpu_din[i]  = din;
        cpu_rd[i]   = rd;
        cpu_wr[i]   = wr;
        stalls = 0;
        done   = 0;
        dout   = 16'h0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (cpu_stall[i]) begin
                chk("no_wr_in_stall", int'(mem_wr[i]), 0);
                if (!hit && c >= 1 && c <= W) begin
                    chk("fill_rd", int'(mem_rd[i]), 1);
                    chk("fill_addr", int'(mem_addr[i]), base + 2 * (c - 1));
                end else begin
                    chk("fill_rd_quiet", int'(mem_rd[i]), 0);
                end
                stalls++;
            end else begin
                done = 1;
                chk("stall_cycles", stalls, exp_st);
                chk("done_mem_rd", int'(mem_rd[i]), 0);
                if (wr) begin
                    chk("wt_mem_wr", int'(mem_wr[i]), 1);
                    chk("wt_addr", int'(mem_addr[i]), a & 16'hFFFE);
                    chk("wt_din", int'(mem_din[i]), int'(din));
                end else begin
                    chk("rd_mem_wr", int'(mem_wr[i]), 0);
                    chk("rd_data", int'(cpu_dout[i]), int'(mem_rdw(i, a >> 1)));
                end
                dout = cpu_dout[i];
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("access_timeout", 0, 1);
        cpu_rd[i] = 1'b0;
        cpu_wr[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int st, nv, c;
        logic [15:0] d;
        rst_n  = 2'b00;
        cpu_rd = 2'b00;
        cpu_wr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cpu_addr[i] = 16'h0;
            cpu_din[i]  = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 2'b11;
        model_reset(0);
        model_reset(1);
        started = 1;

        // reset state
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_stall", int'(cpu_stall[i]), 0);
            chk("reset_mem_rd", int'(mem_rd[i]), 0);
            chk("reset_mem_wr", int'(mem_wr[i]), 0);
        end
        @(posedge clk);
        #1;

        // cold read miss, then hit in the same block
        do_access(0, 16'h0000, 1, 0, 16'h0, st, d);
        chk("t1_stall_13", st, 13);
        chk("t1_data", int'(d), 16'h3C3B);
        do_access(0, 16'h000A, 1, 0, 16'h0, st, d);
        chk("t1_hit_stall", st, 0);
        chk("t1_hit_data", int'(d), 16'h2B26);

        // write miss: fill then write-through
        do_access(0, 16'h0012, 0, 1, 16'hBEEF, st, d);
        chk("t2_wmiss_stall", st, 13);
        do_access(0, 16'h0012, 1, 0, 16'h0, st, d);
        chk("t2_rd_stall", st, 0);
        chk("t2_rd_data", int'(d), 16'hBEEF);

        // rd and wr together act as a write
        do_access(0, 16'h0004, 1, 1, 16'h1234, st, d);
        chk("t6_stall", st, 0);
        do_access(0, 16'h0004, 1, 0, 16'h0, st, d);
        chk("t6_data", int'(d), 16'h1234);

        // conflicts in set 0
        do_access(0, 16'h1000, 1, 0, 16'h0, st, d);
        chk("t3_fill_b", st, 13);
        do_access(0, 16'h0000, 1, 0, 16'h0, st, d);
        chk("t3_hit_a", st, 0);
        do_access(0, 16'h2000, 1, 0, 16'h0, st, d);
        chk("t3_miss_c", st, 13);
        do_access(0, 16'h0000, 1, 0, 16'h0, st, d);
        chk("t3_a_kept", st, 0);
        do_access(0, 16'h1000, 1, 0, 16'h0, st, d);
        chk("t3_b_evicted", st, 13);

        // reset in the middle of a fill
        cpu_addr[0] = 16'h3000;
        cpu_rd[0]   = 1'b1;
        nv = 0;
        c  = 0;
        while (nv < 3 && c < 60) begin
            @(negedge clk);
            if (mem_valid[0]) nv++;
            c++;
        end
        chk("t5_third_return", nv, 3);
        @(posedge clk);
        #1;
        rst_n[0]  = 1'b0;
        cpu_rd[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        model_reset(0);
        repeat (10) begin
            @(negedge clk);
            chk("t5_no_wr", int'(mem_wr[0]), 0);
            chk("t5_no_stall", int'(cpu_stall[0]), 0);
        end
        @(posedge clk);
        #1;
        do_access(0, 16'h3000, 1, 0, 16'h0, st, d);
        chk("t5_refill", st, 13);

        // direct-mapped: alternating conflicting reads always miss
        for (int k = 0; k < 4; k++) begin
            do_access(1, (k % 2) ? 16'h1000 : 16'h0000, 1, 0, 16'h0, st, d);
            chk("t4_dm_miss", st, 13);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised set-associative, write-through, write-allocate cache with an integrated burst-fill controller, replacing the fixed 128-set direct-mapped cache on the instruction and data ports of the pipeline. It serves CPU reads and writes combinationally on a hit and stalls the pipeline on a miss. On a miss it fills a whole block from a multi-cycle backing memory. Requests to that memory are pipelined, one per cycle, and data returns in order under a valid strobe.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width; address bit 0 is the byte select and is ignored
- SET_BITS, 6, log2 of the set count
- WORD_BITS, 3, log2 of words per block (W = 2^WORD_BITS)
- WAYS, 2, associativity; legal values are 1 or 2
- Derived: TAG_W = ADDR_W - SET_BITS - WORD_BITS - 1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- cpu_addr  in  ADDR_W  request address; must be held stable while cpu_stall=1
- cpu_din  in  DATA_W  write data
- cpu_rd  in  1  read request
- cpu_wr  in  1  write request; takes priority over cpu_rd
- cpu_dout  out  DATA_W  hit word (combinational)
- cpu_stall  out  1  request not complete this cycle
- mem_addr  out  ADDR_W  memory address (word-aligned, bit 0 = 0)
- mem_din  out  DATA_W  write-through data
- mem_rd  out  1  one-cycle read request
- mem_wr  out  1  one-cycle write request
- mem_dout  in  DATA_W  read return data
- mem_valid  in  1  mem_dout valid; returns arrive in request order

## Operation
- Address split:
  - tag = addr[ADDR_W-1 -: TAG_W]
  - set = addr[WORD_BITS+SET_BITS : WORD_BITS+1]
  - word = addr[WORD_BITS:1]
- Per way and set: valid bit, tag, W data words. Per set: 1 LRU bit (meaningful only when WAYS=2) naming the way to evict next.
- Hit: (cpu_rd|cpu_wr) and some way is valid with a matching tag. Both ways hitting is impossible by construction.
- States: IDLE and FILL.
- IDLE, read hit:
  - cpu_dout = hit word; cpu_stall=0.
  - LRU points to the other way.
- IDLE, write hit:
  - Hit word <= cpu_din at the clock edge; cpu_stall=0.
  - Same cycle: mem_wr=1, mem_addr=cpu_addr with bit 0 cleared, mem_din=cpu_din.
  - LRU is updated as for a read hit.
- IDLE, miss:
  - cpu_stall=1 combinationally.
  - Latch tag and set.
  - Choose the victim way: first invalid way (way 0 preferred); otherwise the LRU way.
  - Clear the request and receive counters, then go to FILL.
- FILL, requests:
  - While the request counter is below W: mem_rd=1, mem_addr={latched tag, set, req_cnt, 1'b0}; req_cnt increments.
- FILL, returns:
  - Each mem_valid writes mem_dout into the victim way at word rcv_cnt; rcv_cnt increments.
  - On the edge accepting word W-1: write the victim tag, set valid=1, point LRU away from the victim, go to IDLE.
- Back in IDLE the held request re-evaluates as a hit and completes as above. A write miss therefore completes as fill, then write hit, then write-through.
- cpu_stall = (state==FILL) | miss.
- mem_rd and mem_wr are never both 1. mem_wr=0 in FILL. mem_valid is ignored in IDLE.
- With no request (cpu_rd=cpu_wr=0): no state change, cpu_stall=0, no memory traffic.

## Timing
- Reset (rst_n=0 at an edge):
  - State IDLE; all valid and LRU bits 0; counters 0.
  - Post-reset outputs: cpu_stall=0 (no request), mem_rd=0, mem_wr=0. cpu_dout and mem_addr are don't-care.
- Reset mid-FILL aborts the fill. No tag is written, so the victim stays invalid. Late mem_valid pulses are ignored.
- Hit latency: 0 stall cycles.
- Miss with memory latency L (mem_valid L cycles after the matching mem_rd, L>=1):
  - Cycle 0: miss detected.
  - Cycles 1..W: mem_rd high.
  - Cycle W+L: last return.
  - Cycle W+L+1: hit, stall low.
  - Stall cycles = W+L+1.
- rcv_cnt and req_cnt are WORD_BITS+1 bits wide; the block never wraps past W.

## Test plan
- After reset, read 0x0000 (WAYS=2, W=8, memory L=4) -> stall exactly 13 cycles; mem_rd on cycles 1-8 with mem_addr 0x0000..0x000E; then cpu_dout = mem[0x0000]; next read of 0x000A hits with no stall.
- Write 0xBEEF to 0x0012 (miss) -> fill of block 0x0010-0x001E, then one cycle with mem_wr=1, mem_addr=0x0012, mem_din=0xBEEF; a subsequent read of 0x0012 returns 0xBEEF with no stall.
- Conflict, SET_BITS=6: fill tag A at 0x0000, then tag B at 0x1000 (same set; both cached), read 0x0000 (hit, LRU->B), miss on 0x2000 -> B evicted; 0x0000 still hits, 0x1000 misses.
- WAYS=1: alternate reads of 0x0000 and 0x1000 -> every access misses and refills.
- Assert rst_n=0 after the 3rd mem_valid of a fill, then keep delivering returns -> no writes occur; a read of the same address afterward misses and performs a full 8-word fill.
- cpu_rd=cpu_wr=1 on a hit at 0x0004 with cpu_din=0x1234 -> treated as a write: mem_wr=1 and cached word = 0x1234.
